memory_access_stage: RTL and testbench

- MA stage of the 16-bit pipelined core. Sits between execute (EX) and register write-back.
- Registers EX results and performs load/store transactions on a req/ack data-memory port.
- Drives the `*_ma` bus consumed by write-back, and stalls EX while a memory transaction is outstanding.

---
 rtl/memory_access_stage.sv | 168 ++++++++++++++++
 tb/tb_memory_access_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_stage
// Description : MA stage of the 16-bit core; registers EX results and runs
//               load/store transactions on a req/ack data-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access_stage #(
  parameter int                DATA_W   = 16,
  parameter int                IDX_W    = 5,
  parameter int                CTRL_W   = 5,
  parameter logic [CTRL_W-1:0] LOAD_OP  = 5'b01100,
  parameter logic [CTRL_W-1:0] STORE_OP = 5'b01101,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_ex,
  input  logic [IDX_W-1:0]  dest_reg_index_ex,
  input  logic              dest_reg_write_en_ex,
  input  logic [DATA_W-1:0] result_ex,
  input  logic [DATA_W-1:0] store_data_ex,
  input  logic [CTRL_W-1:0] control_ex,
  output logic              stall_ma,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [IDX_W-1:0]  dest_reg_index_ma,
  output logic              dest_reg_write_en_ma,
  output logic [DATA_W-1:0] result_ma,
  output logic [DATA_W-1:0] data_ma,
  output logic [CTRL_W-1:0] control_ma,
  output logic              mem_err
);

  localparam int              c_cnt_w   = $clog2(TIMEOUT + 1);
  localparam [c_cnt_w-1:0]    c_cnt_max = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [IDX_W-1:0]    r_hold_idx;
  logic                r_hold_we;
  logic [DATA_W-1:0]   r_hold_result;
  logic [CTRL_W-1:0]   r_hold_ctrl;

  logic w_is_mem;
  logic w_is_store;
  logic w_accept_alu;
  logic w_accept_mem;
  logic w_done;
  logic w_abort;

  assign w_is_store = (control_ex == STORE_OP);
  assign w_is_mem   = valid_ex && ((control_ex == LOAD_OP) || w_is_store);
  assign stall_ma   = (r_state == ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept_alu = 1'b0;
    w_accept_mem = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mem) begin
          w_accept_mem = 1'b1;
          w_state_nxt  = ST_WAIT;
        end else if (valid_ex) begin
          w_accept_alu = 1'b1;
        end
      end
      ST_WAIT: begin
        // An ack arriving in the final timeout cycle still completes the op.
        if (mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_cnt_max) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_hold_idx    <= '0;
      r_hold_we     <= 1'b0;
      r_hold_result <= '0;
      r_hold_ctrl   <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_err       <= 1'b0;
    end else begin
      if (w_accept_mem) begin
        r_cnt         <= '0;
        r_hold_idx    <= dest_reg_index_ex;
        r_hold_we     <= dest_reg_write_en_ex;
        r_hold_result <= result_ex;
        r_hold_ctrl   <= control_ex;
        mem_req       <= 1'b1;
        mem_we        <= w_is_store;
        mem_addr      <= result_ex;
        mem_wdata     <= w_is_store ? store_data_ex : '0;
      end else if (w_done || w_abort) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      if (w_abort) begin
        mem_err <= 1'b1;
      end
    end
  end

  // Write-back bus: a bubble (all zero) unless an instruction retires this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_reg_index_ma    <= '0;
      dest_reg_write_en_ma <= 1'b0;
      result_ma            <= '0;
      data_ma              <= '0;
      control_ma           <= '0;
    end else if (w_accept_alu) begin
      dest_reg_index_ma    <= dest_reg_index_ex;
      dest_reg_write_en_ma <= dest_reg_write_en_ex;
      result_ma            <= result_ex;
      data_ma              <= '0;
      control_ma           <= control_ex;
    end else if (w_done) begin
      dest_reg_index_ma    <= r_hold_idx;
      dest_reg_write_en_ma <= r_hold_we && (r_hold_ctrl != STORE_OP);
      result_ma            <= r_hold_result;
      data_ma              <= (r_hold_ctrl == LOAD_OP) ? mem_rdata : '0;
      control_ma           <= r_hold_ctrl;
    end else begin
      dest_reg_index_ma    <= '0;
      dest_reg_write_en_ma <= 1'b0;
      result_ma            <= '0;
      data_ma              <= '0;
      control_ma           <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_stage
// Description : Self-checking bench for memory_access_stage (vectors + queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_stage;

  localparam logic [4:0] c_load  = 5'b01100;
  localparam logic [4:0] c_store = 5'b01101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ex;
  logic [4:0]  dest_reg_index_ex;
  logic        dest_reg_write_en_ex;
  logic [15:0] result_ex;
  logic [15:0] store_data_ex;
  logic [4:0]  control_ex;
  logic        stall_ma;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [4:0]  dest_reg_index_ma;
  logic        dest_reg_write_en_ma;
  logic [15:0] result_ma;
  logic [15:0] data_ma;
  logic [4:0]  control_ma;
  logic        mem_err;

  memory_access_stage dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .valid_ex             (valid_ex),
    .dest_reg_index_ex    (dest_reg_index_ex),
    .dest_reg_write_en_ex (dest_reg_write_en_ex),
    .result_ex            (result_ex),
    .store_data_ex        (store_data_ex),
    .control_ex           (control_ex),
    .stall_ma             (stall_ma),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ack              (mem_ack),
    .dest_reg_index_ma    (dest_reg_index_ma),
    .dest_reg_write_en_ma (dest_reg_write_en_ma),
    .result_ma            (result_ma),
    .data_ma              (data_ma),
    .control_ma           (control_ma),
    .mem_err              (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [4:0]  idx;
    logic        we;
    logic [15:0] result;
    logic [15:0] sdata;
    logic [4:0]  wait_cyc;   // 0 = ALU op, else WAIT cycle carrying the ack
    logic [15:0] rdata;
    logic [4:0]  exp_idx;
    logic        exp_we;
    logic [15:0] exp_result;
    logic [15:0] exp_data;
    logic        exp_mwe;
    logic [15:0] exp_wdata;
  } vec_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic        we;
    logic [15:0] result;
    logic [15:0] data;
    logic [4:0]  ctrl;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every non-bubble write-back cycle must match the next queued instruction.
  always @(negedge clk) begin
    if (rst_n && (dest_reg_index_ma != 0 || dest_reg_write_en_ma || result_ma != 0 ||
                  data_ma != 0 || control_ma != 0)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ma: got idx=%0d we=%0b res=%0h data=%0h ctrl=%0h expected bubble",
                 dest_reg_index_ma, dest_reg_write_en_ma, result_ma, data_ma, control_ma);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ma_bus", {dest_reg_index_ma, dest_reg_write_en_ma, result_ma, data_ma, control_ma}, e);
      end
    end
  end

  task automatic drive_ex(input logic v, input logic [4:0] c, input logic [4:0] i,
                          input logic w, input logic [15:0] r, input logic [15:0] s);
    valid_ex = v; control_ex = c; dest_reg_index_ex = i;
    dest_reg_write_en_ex = w; result_ex = r; store_data_ex = s;
  endtask

  task automatic issue(input vec_t v);
    @(posedge clk); #1;
    drive_ex(1'b1, v.ctrl, v.idx, v.we, v.result, v.sdata);
    sb.push_back({v.exp_idx, v.exp_we, v.exp_result, v.exp_data, v.ctrl});
    @(posedge clk); #1;
    drive_ex(1'b0, 5'd0, 5'd0, 1'b0, 16'h0, 16'h0);
    for (int i = 1; i <= int'(v.wait_cyc); i++) begin
      chk("wait_stall", stall_ma, 1);
      chk("wait_req", mem_req, 1);
      chk("wait_we", mem_we, v.exp_mwe);
      chk("wait_addr", mem_addr, v.result);
      chk("wait_wdata", mem_wdata, v.exp_wdata);
      if (i == int'(v.wait_cyc)) begin
        mem_ack = 1'b1; mem_rdata = v.rdata;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    end
    chk("post_stall", stall_ma, 0);
    chk("post_req", mem_req, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    vecs[0] = '{5'b00001, 5'd3,  1'b1, 16'h1234, 16'h0000, 5'd0,  16'h0000,
                5'd3,  1'b1, 16'h1234, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{c_load,   5'd7,  1'b1, 16'h0040, 16'h0000, 5'd2,  16'hBEEF,
                5'd7,  1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'h0000};
    vecs[2] = '{c_store,  5'd9,  1'b1, 16'h0010, 16'hA5A5, 5'd1,  16'h7777,
                5'd9,  1'b0, 16'h0010, 16'h0000, 1'b1, 16'hA5A5};
    vecs[3] = '{5'b00010, 5'd31, 1'b0, 16'hFFFF, 16'h1111, 5'd0,  16'h0000,
                5'd31, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'h0000};
    vecs[4] = '{c_load,   5'd1,  1'b1, 16'h8000, 16'h2222, 5'd15, 16'h0001,
                5'd1,  1'b1, 16'h8000, 16'h0001, 1'b0, 16'h0000};
    vecs[5] = '{5'b11111, 5'd0,  1'b1, 16'h0000, 16'h0000, 5'd0,  16'h0000,
                5'd0,  1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[6] = '{c_store,  5'd4,  1'b0, 16'h00AA, 16'h5A5A, 5'd3,  16'h3333,
                5'd4,  1'b0, 16'h00AA, 16'h0000, 1'b1, 16'h5A5A};
    vecs[7] = '{c_load,   5'd2,  1'b1, 16'h1357, 16'h4444, 5'd1,  16'h0000,
                5'd2,  1'b1, 16'h1357, 16'h0000, 1'b0, 16'h0000};

    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    drive_ex(1'b0, 5'd0, 5'd0, 1'b0, 16'h0, 16'h0);
    #2;
    chk("reset_ma", {dest_reg_index_ma, dest_reg_write_en_ma, result_ma, data_ma, control_ma}, 0);
    chk("reset_mem", {stall_ma, mem_req, mem_we, mem_err, mem_addr, mem_wdata}, 0);
    #10 rst_n = 1'b1;

    foreach (vecs[k]) issue(vecs[k]);
    chk("no_err_after_ack_at_limit", mem_err, 0);

    // Ack while idle must not produce anything.
    @(posedge clk); #1; mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    chk("idle_ack_stall", stall_ma, 0);
    chk("idle_ack_req", mem_req, 0);

    // Stall handoff: ALU op held on EX while the load waits.
    @(posedge clk); #1;
    drive_ex(1'b1, c_load, 5'd5, 1'b1, 16'h0100, 16'h0);
    sb.push_back({5'd5, 1'b1, 16'h0100, 16'hC0DE, c_load});
    sb.push_back({5'd6, 1'b1, 16'h4321, 16'h0000, 5'b00011});
    @(posedge clk); #1;
    drive_ex(1'b1, 5'b00011, 5'd6, 1'b1, 16'h4321, 16'h9999);
    chk("handoff_stall", stall_ma, 1);
    mem_ack = 1'b1; mem_rdata = 16'hC0DE;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    chk("handoff_release", stall_ma, 0);
    @(posedge clk); #1;
    drive_ex(1'b0, 5'd0, 5'd0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("handoff_drained", sb.size(), 0);

    // Timeout: no ack at all.
    @(posedge clk); #1;
    drive_ex(1'b1, c_load, 5'd10, 1'b1, 16'h0F00, 16'h0);
    @(posedge clk); #1;
    drive_ex(1'b0, 5'd0, 5'd0, 1'b0, 16'h0, 16'h0);
    req_cycles = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      req_cycles++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", req_cycles, 15);
    chk("timeout_err", mem_err, 1);
    chk("timeout_stall", stall_ma, 0);
    issue(vecs[0]);
    chk("timeout_err_sticky", mem_err, 1);

    // Reset on the 3rd WAIT cycle clears everything without a clock edge.
    @(posedge clk); #1;
    drive_ex(1'b1, c_load, 5'd8, 1'b1, 16'h0200, 16'h0);
    @(posedge clk); #1;
    drive_ex(1'b0, 5'd0, 5'd0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem", {stall_ma, mem_req, mem_we, mem_err}, 0);
    chk("async_rst_ma", {dest_reg_index_ma, dest_reg_write_en_ma, result_ma, data_ma, control_ma}, 0);
    @(negedge clk); rst_n = 1'b1;
    issue(vecs[3]);
    chk("post_reset_err", mem_err, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
